// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the L1 data-cache line responder: line geometry and FSM state encoding.
package dcache_mem_responder_pkg;

  localparam int OFFSET_WIDTH_DEF = 5;
  localparam int WORD_BYTES       = 4;
  localparam int WORDS_PER_LINE   = 2 ** (OFFSET_WIDTH_DEF - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_mem_responder.sv
// Serialises one cache-line fill or writeback into single-word memory accesses and
// streams fill words back to the cache, pulsing mmu_mem_ready once the line is finished.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    req_ready,
  output logic [OFFSET_WIDTH-3:0] wb_word_idx,
  input  logic [31:0]             wb_data,
  output logic                    fill_valid,
  output logic [OFFSET_WIDTH-3:0] fill_word_idx,
  output logic [31:0]             fill_data,
  output logic                    mmu_mem_ready,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack
);

  localparam int IDX_W = OFFSET_WIDTH - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e                  state_r, state_s;
  logic [IDX_W-1:0]        cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0]   base_r, base_s;
  // WR: 0 = loading mem_wdata, 1 = access in flight. DONE: 0 = final fill drains, 1 = pulse.
  logic                    sub_r, sub_s;
  logic [31:0]             wdata_r;
  logic                    fill_valid_r;
  logic [IDX_W-1:0]        fill_idx_r;
  logic [31:0]             fill_data_r;
  logic                    mem_en_s, mem_we_s, done_pulse_s, fill_take_s, wdata_load_s;
  logic                    unused_addr_bits_s;

  assign unused_addr_bits_s = ^req_addr[OFFSET_WIDTH-1:0];

  // Next-state, counter and access-strobe decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    base_s       = base_r;
    sub_s        = sub_r;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    done_pulse_s = 1'b0;
    fill_take_s  = 1'b0;
    wdata_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          base_s  = {req_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          cnt_s   = '0;
          sub_s   = 1'b0;
          state_s = req_write ? ST_WR : ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        mem_en_s = 1'b1;
        if (mem_ack) begin
          fill_take_s = 1'b1;
          if (cnt_r == LAST_IDX) begin
            cnt_s   = '0;
            sub_s   = 1'b0;
            state_s = ST_DONE;
          end else begin
            cnt_s = cnt_r + ONE_IDX;
          end
        end else begin
          state_s = ST_RD;
        end
      end
      ST_WR: begin
        if (!sub_r) begin
          wdata_load_s = 1'b1;
          sub_s        = 1'b1;
        end else begin
          mem_en_s = 1'b1;
          mem_we_s = 1'b1;
          if (mem_ack) begin
            sub_s = 1'b0;
            if (cnt_r == LAST_IDX) begin
              cnt_s   = '0;
              state_s = ST_DONE;
            end else begin
              cnt_s = cnt_r + ONE_IDX;
            end
          end else begin
            state_s = ST_WR;
          end
        end
      end
      ST_DONE: begin
        if (!sub_r) begin
          sub_s = 1'b1;
        end else begin
          done_pulse_s = 1'b1;
          sub_s        = 1'b0;
          state_s      = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        sub_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and fill-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      base_r       <= '0;
      sub_r        <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      fill_valid_r <= 1'b0;
      fill_idx_r   <= '0;
      fill_data_r  <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      base_r       <= base_s;
      sub_r        <= sub_s;
      fill_valid_r <= fill_take_s;
      if (wdata_load_s) begin
        wdata_r <= wb_data;
      end
      if (fill_take_s) begin
        fill_idx_r  <= cnt_r;
        fill_data_r <= mem_rdata;
      end
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign wb_word_idx   = cnt_r;
  assign fill_valid    = fill_valid_r;
  assign fill_word_idx = fill_idx_r;
  assign fill_data     = fill_data_r;
  assign mmu_mem_ready = done_pulse_s;
  assign mem_en        = mem_en_s;
  assign mem_we        = mem_we_s;
  assign mem_addr      = base_r + ADDR_WIDTH'({cnt_r, 2'b00});
  assign mem_wdata     = wdata_r;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: a transaction-level line model checks every cycle,
// while per-test literals pin addresses, data, and pulse counts.
module tb_dcache_mem_responder;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [2:0]  wb_word_idx;
  logic [31:0] wb_data;
  logic        fill_valid;
  logic [2:0]  fill_word_idx;
  logic [31:0] fill_data;
  logic        mmu_mem_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  dcache_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready), .wb_word_idx(wb_word_idx),
    .wb_data(wb_data), .fill_valid(fill_valid), .fill_word_idx(fill_word_idx),
    .fill_data(fill_data), .mmu_mem_ready(mmu_mem_ready), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // The cache side presents writeback word idx as 0xA0+idx.
  assign wb_data = 32'hA0 + {29'd0, wb_word_idx};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a << 4) ^ 32'hC0DE_0000;
  endfunction

  // Memory responder knobs
  logic       force_ack = 1'b0;
  int         ack_delay = 0;
  logic       stall_en  = 1'b0;
  logic [2:0] stall_idx = 3'd0;

  // Line-level model state and logs
  logic        m_busy = 1'b0, m_write = 1'b0, m_last = 1'b0;
  logic [31:0] m_base = 32'h0;
  int          m_k = 0, m_wait = 0;
  logic        pend_v = 1'b0;
  logic [2:0]  pend_idx;
  logic [31:0] pend_data;
  logic        prev_hold = 1'b0, prev_we;
  logic [31:0] prev_addr, prev_wdata;
  int          accept_cnt = 0, n_pulse = 0, stall_cycles = 0;
  logic [31:0] stall_watch = 32'hFFFF_FFFF;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_data[$];
  logic [31:0] fill_log[$];
  logic [31:0] fill_dlog[$];

  // Backing memory: ack after a per-word latency, or constantly when force_ack.
  initial begin
    int wait_cnt;
    int lat;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      lat = (stall_en && mem_addr[4:2] == stall_idx) ? 10 : ack_delay;
      if (force_ack) mem_ack = 1'b1;
      else if (mem_en && wait_cnt >= lat) mem_ack = 1'b1;
      else mem_ack = 1'b0;
      if (mem_en && !mem_ack) wait_cnt++; else wait_cnt = 0;
      mem_rdata = (mem_en && mem_ack) ? rd_model(mem_addr)
                                      : (32'hBAD0_0000 | 32'($urandom_range(0, 65535)));
    end
  end

  // Per-cycle compare against the line model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 1'b0; m_last = 1'b0; pend_v = 1'b0; prev_hold = 1'b0;
        continue;
      end
      check("fill_valid", {31'd0, fill_valid}, {31'd0, pend_v});
      if (pend_v && fill_valid) begin
        check("fill_idx", {29'd0, fill_word_idx}, {29'd0, pend_idx});
        check("fill_data", fill_data, pend_data);
        fill_log.push_back({29'd0, fill_word_idx});
        fill_dlog.push_back(fill_data);
      end
      pend_v = 1'b0;
      if (prev_hold) begin
        check("hold_en", {31'd0, mem_en}, 32'd1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_en && mem_addr == stall_watch) stall_cycles++;
      if (mmu_mem_ready) n_pulse++;
      if (!m_busy) begin
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_mem_en", {31'd0, mem_en}, 32'd0);
        check("idle_done", {31'd0, mmu_mem_ready}, 32'd0);
        if (req_valid) begin
          m_busy = 1'b1; m_write = req_write; m_base = req_addr & ~32'h1F;
          m_k = 0; m_last = 1'b0; m_wait = 0; accept_cnt++;
        end
      end else begin
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        if (!m_last) begin
          check("early_done", {31'd0, mmu_mem_ready}, 32'd0);
          if (!m_write) check("rd_en", {31'd0, mem_en}, 32'd1);
          if (mem_en) begin
            check("addr", mem_addr, m_base + 32'(m_k * 4));
            check("we", {31'd0, mem_we}, {31'd0, m_write});
            if (m_write) begin
              check("wdata", mem_wdata, 32'hA0 + 32'(m_k));
              check("wb_idx", {29'd0, wb_word_idx}, 32'(m_k));
            end
            if (mem_ack) begin
              acc_addr.push_back(mem_addr);
              if (m_write) acc_data.push_back(mem_wdata);
              else begin
                acc_data.push_back(mem_rdata);
                pend_v = 1'b1; pend_idx = 3'(m_k); pend_data = rd_model(mem_addr);
              end
              m_k++;
              if (m_k == WORDS) begin m_last = 1'b1; m_wait = 0; end
            end
          end
        end else begin
          m_wait++;
          check("done_mem_en", {31'd0, mem_en}, 32'd0);
          if (mmu_mem_ready) begin
            check("done_gap", {31'd0, m_wait >= (m_write ? 1 : 2)}, 32'd1);
            m_busy = 1'b0;
          end else if (m_wait >= 4) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no mmu_mem_ready expected pulse within 4 cycles");
            m_busy = 1'b0;
          end
        end
      end
      prev_hold = mem_en && !mem_ack;
      prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
    end
  end

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete(); fill_log.delete(); fill_dlog.delete();
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr);
    int start;
    start = accept_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    for (int i = 0; i < 40 && accept_cnt == start; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("req_taken", 32'(accept_cnt - start), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && m_busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_in_budget", {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, f0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
    check("rst_fill_data", fill_data, 32'h0);
    check("rst_fill_idx", {29'd0, fill_word_idx}, 32'd0);
    check("rst_wb_idx", {29'd0, wb_word_idx}, 32'd0);
    check("rst_done", {31'd0, mmu_mem_ready}, 32'd0);

    // Fill with mem_ack tied high
    clear_logs(); p0 = n_pulse; force_ack = 1'b1;
    do_req(1'b0, 32'h0000_1234);
    wait_idle(40);
    force_ack = 1'b0;
    check("t1_n_acc", 32'(acc_addr.size()), 32'd8);
    check("t1_n_fill", 32'(fill_log.size()), 32'd8);
    check("t1_pulses", 32'(n_pulse - p0), 32'd1);
    if (acc_addr.size() == 8 && fill_log.size() == 8) begin
      check("t1_addr0", acc_addr[0], 32'h0000_1220);
      check("t1_addr7", acc_addr[7], 32'h0000_123C);
      check("t1_fidx0", fill_log[0], 32'd0);
      check("t1_fidx7", fill_log[7], 32'd7);
      check("t1_fdata0", fill_dlog[0], 32'hC0DF_2200);
    end

    // Writeback, ack 3 cycles into each word
    clear_logs(); p0 = n_pulse; ack_delay = 3;
    do_req(1'b1, 32'h0000_0080);
    wait_idle(100);
    check("t2_n_acc", 32'(acc_addr.size()), 32'd8);
    check("t2_n_fill", 32'(fill_log.size()), 32'd0);
    check("t2_pulses", 32'(n_pulse - p0), 32'd1);
    if (acc_addr.size() == 8) begin
      check("t2_addr0", acc_addr[0], 32'h0000_0080);
      check("t2_data0", acc_data[0], 32'h0000_00A0);
      check("t2_addr7", acc_addr[7], 32'h0000_009C);
      check("t2_data7", acc_data[7], 32'h0000_00A7);
    end

    // req_valid held through a fill: exactly two transfers
    ack_delay = 1; p0 = n_pulse; a0 = accept_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000;
    for (int i = 0; i < 200 && accept_cnt < a0 + 2; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle(60);
    check("t3_accepts", 32'(accept_cnt - a0), 32'd2);
    check("t3_pulses", 32'(n_pulse - p0), 32'd2);

    // Stall: ack withheld 10 cycles on word 3
    clear_logs(); ack_delay = 0; stall_en = 1'b1; stall_idx = 3'd3;
    stall_cycles = 0; stall_watch = 32'h0000_200C;
    do_req(1'b1, 32'h0000_2000);
    wait_idle(100);
    check("t4_stall_cycles", 32'(stall_cycles), 32'd11);
    stall_cycles = 0; stall_watch = 32'h0000_300C;
    do_req(1'b0, 32'h0000_3000);
    wait_idle(100);
    check("t4_stall_cycles_rd", 32'(stall_cycles), 32'd11);
    stall_en = 1'b0; stall_watch = 32'hFFFF_FFFF;

    // Reset while word 4 of a fill is outstanding
    ack_delay = 1; p0 = n_pulse;
    do_req(1'b0, 32'h0000_5000);
    for (int i = 0; i < 40 && !(m_k == 4 && mem_en); i++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_w4", 32'(m_k), 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_ready", {31'd0, req_ready}, 32'd1);
    check("t5_mem_en", {31'd0, mem_en}, 32'd0);
    check("t5_fill_valid", {31'd0, fill_valid}, 32'd0);
    check("t5_no_pulse", 32'(n_pulse - p0), 32'd0);
    clear_logs(); ack_delay = 0;
    do_req(1'b0, 32'h0000_6040);
    wait_idle(60);
    check("t5_refill_pulse", 32'(n_pulse - p0), 32'd1);
    check("t5_refill_n", 32'(fill_log.size()), 32'd8);

    // Spurious mem_ack while idle
    f0 = fill_log.size(); a0 = accept_cnt; p0 = n_pulse;
    @(posedge clk); #1;
    force_ack = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    force_ack = 1'b0;
    check("t6_no_fill", 32'(fill_log.size() - f0), 32'd0);
    check("t6_no_accept", 32'(accept_cnt - a0), 32'd0);
    check("t6_no_pulse", 32'(n_pulse - p0), 32'd0);
    check("t6_ready", {31'd0, req_ready}, 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
